// File: rtl/fe_mod_mul.sv
// Serial multiplier in GF(2^255-19): r = a*b mod Q, MSB-first interleaved double-and-add,
// one multiplier bit per cycle, start/done responder handshake.
module fe_mod_mul #(
  parameter int unsigned  W = 255,
  parameter logic [255:0] Q = (256'd1 << 255) - 256'd19
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [255:0] a,
  input  logic [255:0] b,
  output logic [255:0] r,
  output logic         done
);

  localparam logic [255:0] OPERAND_MASK = (256'd1 << W) - 256'd1;
  localparam logic [7:0]   CNT_TOP      = 8'(W - 1);

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  state_t       state, state_next;
  logic [255:0] a_r, b_r;
  logic [255:0] acc, acc_next;
  logic [255:0] dbl, dbl_red, sum, sum_red;
  logic [7:0]   cnt;
  logic         b_bit;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case leaves it unassigned and infers a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = LOAD;
      LOAD:    state_next = RUN;
      RUN:     if (cnt == 8'd0) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign done = (state == IDLE) & ~start;

  // acc < Q keeps 2*acc and d + a_r below 2^256, so each step needs at most one subtract.
  always_comb begin
    b_bit    = b_r[cnt];
    dbl      = acc << 1;
    dbl_red  = (dbl >= Q) ? dbl - Q : dbl;
    sum      = dbl_red + a_r;
    sum_red  = (sum >= Q) ? sum - Q : sum;
    acc_next = b_bit ? sum_red : dbl_red;
  end

  // NOTE: operand registers carry no reset; they are always written at
  // capture time before anything reads them.
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      a_r <= a & OPERAND_MASK;
      b_r <= b & OPERAND_MASK;
    end else if (state == LOAD && a_r >= Q) begin
      a_r <= a_r - Q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      cnt <= '0;
      r   <= '0;
    end else begin
      case (state)
        LOAD: begin
          acc <= '0;
          cnt <= CNT_TOP;
        end
        RUN: begin
          acc <= acc_next;
          if (cnt == 8'd0) r <= acc_next;
          else             cnt <= cnt - 8'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fe_mod_mul.sv
// Scoreboard bench for fe_mod_mul: driver pushes expected products, a monitor that
// tracks the handshake timing pops and compares them when each operation completes.
module tb_fe_mod_mul;

  localparam logic [255:0] Q = (256'd1 << 255) - 256'd19;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [255:0] a = '0;
  logic [255:0] b = '0;
  logic [255:0] r;
  logic         done;

  int n_cmp = 0;
  int n_mis = 0;
  logic [255:0] exp_q[$];

  fe_mod_mul dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .r     (r),
    .done  (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference: (a mod Q) * (b mod 2^255) mod Q with wide integer arithmetic.
  function automatic logic [255:0] ref_mul(input logic [255:0] x, input logic [255:0] y);
    logic [511:0] xm, ym, qw, p;
    qw = {256'd0, Q};
    xm = {257'd0, x[254:0]} % qw;
    ym = {257'd0, y[254:0]};
    p  = (xm * ym) % qw;
    return p[255:0];
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Monitor: models when the responder is busy and when a result becomes due.
  int busy = 0;
  bit fin  = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy = 0;
      fin  = 1'b0;
      exp_q.delete();
    end else if (busy == 0) begin
      fin = 1'b0;
      if (start) busy = 256;
    end else begin
      busy = busy - 1;
      fin  = (busy == 0);
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("done", {255'd0, done}, {255'd0, (busy == 0) && !start});
      if (fin) begin
        fin = 1'b0;
        if (exp_q.size() == 0) check("unexpected_result", r, 256'hx);
        else                   check("r", r, exp_q.pop_front());
      end
    end
  end

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 600) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!done) check("done_timeout", 256'd0, 256'd1);
  endtask

  task automatic launch(input logic [255:0] x, input logic [255:0] y, input logic [255:0] exp);
    @(posedge clk);
    #1;
    a = x;
    b = y;
    start = 1'b1;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic run_op(input logic [255:0] x, input logic [255:0] y, input logic [255:0] exp);
    int n;
    launch(x, y, exp);
    wait_done(n);
  endtask

  initial begin
    int n;
    logic [255:0] half_q1, x, y;

    repeat (2) @(posedge clk);
    #1;
    check("reset_r", r, 256'd0);
    check("reset_done", {255'd0, done}, 256'd1);
    rst_n = 1'b1;

    // Zero multiplicand, exact latency.
    launch(256'd0, 256'd12345, 256'd0);
    wait_done(n);
    check("latency", 256'(n), 256'd256);

    half_q1 = (Q + 256'd1) >> 1;
    run_op(Q - 256'd1, Q - 256'd1, 256'd1);
    run_op(256'd2, half_q1, 256'd1);
    run_op((256'd1 << 255) - 256'd1, 256'd2, 256'd36);
    run_op(256'd1 << 128, 256'd1 << 127, 256'd19);
    run_op(Q, 256'd7, 256'd0);
    run_op(Q + 256'd5, 256'd3, 256'd15);
    run_op({1'b1, 255'd4}, {1'b1, 255'd9}, 256'd36);

    // A second start mid-operation is dropped; r holds through idle cycles.
    launch(256'd3, 256'd5, 256'd15);
    repeat (99) @(posedge clk);
    #1;
    a = 256'd7;
    b = 256'd7;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(n);
    repeat (5) @(posedge clk);
    #1;
    check("r_hold", r, 256'd15);

    // Reset mid-operation aborts it.
    launch(256'd3, 256'd5, 256'd15);
    repeat (49) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_r", r, 256'd0);
    check("abort_done", {255'd0, done}, 256'd1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("post_reset_r", r, 256'd0);
    run_op(256'd3, 256'd5, 256'd15);

    // Random back-to-back operations with start held high.
    for (int i = 0; i < 30; i++) begin
      x = rand256();
      y = rand256();
      if (i % 5 == 1) x = Q + 256'($urandom_range(0, 20));
      if (i % 5 == 2) y = Q - 256'($urandom_range(1, 4));
      a = x;
      b = y;
      start = 1'b1;
      exp_q.push_back(ref_mul(x, y));
      @(posedge clk);
      repeat (256) @(posedge clk);
      #1;
    end
    start = 1'b0;
    wait_done(n);
    repeat (3) @(posedge clk);
    #1;
    check("queue_empty", 256'(exp_q.size()), 256'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
